// File: rtl/serial_sub_pkg.sv
// Shared definitions for the serial 2-bit-per-cycle subtractor.
package serial_sub_pkg;

    // Default operand width; must be even and at least 2.
    localparam int DEFAULT_WIDTH = 8;

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fs_2bit.sv
// Combinational 2-bit full subtractor: {bout, d} = a - b - bin.
// Built as a + ~b + ~bin; the carry out of that sum is the inverted borrow.
module fs_2bit (
    output logic       bout,
    output logic [1:0] d,
    input  logic       bin,
    input  logic [1:0] a,
    input  logic [1:0] b
);

    logic [2:0] sum;

    // Two's-complement add of the inverted subtrahend and inverted borrow-in.
    always_comb begin
        sum  = {1'b0, a} + {1'b0, ~b} + {2'b00, ~bin};
        d    = sum[1:0];
        bout = ~sum[2];
    end

endmodule

// File: rtl/serial_sub_2bit.sv
// Serial subtractor: computes a - b - bin two bits per clock, LSB pair first,
// reusing a single fs_2bit stage. A request is accepted in IDLE or DONE;
// RUN spends WIDTH/2 edges on the pairs plus one edge to publish the borrow,
// so done rises WIDTH/2+1 edges after the accepting edge.
// Handshake: start is a level sampled at each rising edge and only honoured
// in IDLE/DONE; done is a single-cycle pulse, and d/bout stay valid from that
// cycle until the next accepted start clears them.
module serial_sub_2bit
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic [1:0]       state_o
);

    localparam int PAIRS = WIDTH / 2;
    // One extra bit so the counter can hold PAIRS without wrapping.
    localparam int CW = $clog2(PAIRS) + 1;
    localparam logic [CW-1:0] LAST = CW'(PAIRS);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;

    logic             step_bout;
    logic [1:0]       step_d;

    // The single pair stage always looks at the low pair of the shifting operands.
    fs_2bit u_fs (
        .bout (step_bout),
        .d    (step_d),
        .bin  (borrow_q),
        .a    (a_q[1:0]),
        .b    (b_q[1:0])
    );

    // Next-state and datapath: accept, shift one pair per RUN edge, then publish.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        d_d      = d_q;
        bout_d   = bout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    d_d      = '0;
                    bout_d   = 1'b0;
                    cnt_d    = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    bout_d  = borrow_q;
                end else begin
                    a_d      = a_q >> 2;
                    b_d      = b_q >> 2;
                    borrow_d = step_bout;
                    d_d      = d_q >> 2;
                    d_d[WIDTH-1 -: 2] = step_d;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            d_q      <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign d       = d_q;
    assign bout    = bout_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_serial_sub_2bit.sv
// Bench for serial_sub_2bit: an 8-bit instance for directed, random and
// control scenarios and a 2-bit instance swept exhaustively.
module tb_serial_sub_2bit;

    logic       clk;
    logic       rst;

    logic       start8, bin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, bout8;
    logic [7:0] d8;
    logic [1:0] state8;

    logic       start2, bin2;
    logic [1:0] a2, b2;
    logic       busy2, done2, bout2;
    logic [1:0] d2;
    logic [1:0] state2;

    int n_checks;
    int n_fail;

    logic [8:0] exp_q[$];

    serial_sub_2bit #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .start   (start8),
        .a       (a8),
        .b       (b8),
        .bin     (bin8),
        .busy    (busy8),
        .done    (done8),
        .d       (d8),
        .bout    (bout8),
        .state_o (state8)
    );

    serial_sub_2bit #(.WIDTH(2)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .start   (start2),
        .a       (a2),
        .b       (b2),
        .bin     (bin2),
        .busy    (busy2),
        .done    (done2),
        .d       (d2),
        .bout    (bout2),
        .state_o (state2)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer subtraction; borrow is the sign, d the low bits.
    function automatic logic [8:0] ref8(input logic [7:0] av, input logic [7:0] bv, input logic bi);
        int r;
        r = int'(av) - int'(bv) - int'(bi);
        return {(r < 0), r[7:0]};
    endfunction

    function automatic logic [2:0] ref2(input logic [1:0] av, input logic [1:0] bv, input logic bi);
        int r;
        r = int'(av) - int'(bv) - int'(bi);
        return {(r < 0), r[1:0]};
    endfunction

    // Driver: issue one 8-bit op from a negedge and wait (bounded) for done.
    task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                          output int lat, output logic [8:0] res);
        a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done8) begin
                lat = i;
                break;
            end
        end
        res = {bout8, d8};
    endtask

    task automatic do_op2(input logic [1:0] av, input logic [1:0] bv, input logic bi,
                          output int lat, output logic [2:0] res);
        a2 = av; b2 = bv; bin2 = bi; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done2) begin
                lat = i;
                break;
            end
        end
        res = {bout2, d2};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h11; bin8 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0; start8 = 1'b0;
        n_checks++;
        if ({state8, busy8, done8, bout8, d8} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset8: state=%0d busy=%b done=%b bout=%b d=%h, required all zero",
                     state8, busy8, done8, bout8, d8);
        end
        n_checks++;
        if ({state2, busy2, done2, bout2, d2} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset2: state=%0d busy=%b done=%b bout=%b d=%h, required all zero",
                     state2, busy2, done2, bout2, d2);
        end
    endtask

    task automatic test_directed();
        logic [7:0] va[4] = '{8'h05, 8'h03, 8'h00, 8'h80};
        logic [7:0] vb[4] = '{8'h03, 8'h05, 8'h00, 8'h01};
        logic       vc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [8:0] exp;
        logic [8:0] res;
        int lat;
        for (int k = 0; k < 4; k++) begin
            exp = ref8(va[k], vb[k], vc[k]);
            do_op8(va[k], vb[k], vc[k], lat, res);
            n_checks++;
            if (lat !== 5) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d edges, required 5", k, lat);
            end
            n_checks++;
            if (res !== exp) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: got bout=%b d=%h, required bout=%b d=%h",
                         k, res[8], res[7:0], exp[8], exp[7:0]);
            end
            // done is a single pulse, then the result holds through IDLE.
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                n_checks++;
                if ({done8, busy8, bout8, d8} !== {2'b00, exp}) begin
                    n_fail++;
                    $display("FAIL directed_hold[%0d.%0d]: done=%b busy=%b bout=%b d=%h, required 0 0 %b %h",
                             k, j, done8, busy8, bout8, d8, exp[8], exp[7:0]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] av, bv;
        logic       bi;
        logic [8:0] res, exp;
        int lat;
        for (int k = 0; k < 25; k++) begin
            av = 8'($urandom_range(0, 255));
            bv = 8'($urandom_range(0, 255));
            bi = 1'($urandom_range(0, 1));
            exp_q.push_back(ref8(av, bv, bi));
            do_op8(av, bv, bi, lat, res);
            exp = exp_q.pop_front();
            n_checks++;
            if (lat !== 5 || res !== exp) begin
                n_fail++;
                $display("FAIL random[%0d] a=%h b=%h bin=%b: lat=%0d bout=%b d=%h, required lat=5 bout=%b d=%h",
                         k, av, bv, bi, lat, res[8], res[7:0], exp[8], exp[7:0]);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic test_start_in_run();
        logic [8:0] exp, res;
        int n_done, at;
        exp = ref8(8'h80, 8'h01, 1'b0);
        a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a8 = 8'h11; b8 = 8'hEE; bin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n_done = 0; at = -1; res = '0;
        for (int i = 4; i <= 15; i++) begin
            @(negedge clk);
            if (done8) begin
                n_done++;
                if (at < 0) begin
                    at = i;
                    res = {bout8, d8};
                end
            end
        end
        n_checks++;
        if (n_done !== 1 || at !== 5) begin
            n_fail++;
            $display("FAIL start_in_run_done: %0d pulses at edge %0d, required 1 pulse at edge 5", n_done, at);
        end
        n_checks++;
        if (res !== exp) begin
            n_fail++;
            $display("FAIL start_in_run_result: bout=%b d=%h, required bout=%b d=%h",
                     res[8], res[7:0], exp[8], exp[7:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp1, exp2;
        int lat1, lat2;
        exp1 = ref8(8'h3C, 8'h5A, 1'b1);
        exp2 = ref8(8'hF0, 8'h0F, 1'b0);
        a8 = 8'h3C; b8 = 8'h5A; bin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        lat1 = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done8) begin
                lat1 = i;
                break;
            end
        end
        n_checks++;
        if (lat1 !== 5 || {bout8, d8} !== exp1) begin
            n_fail++;
            $display("FAIL b2b_first: lat=%0d bout=%b d=%h, required lat=5 bout=%b d=%h",
                     lat1, bout8, d8, exp1[8], exp1[7:0]);
        end
        // start still high: the DONE edge must accept the new operands.
        a8 = 8'hF0; b8 = 8'h0F; bin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        n_checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0 || {bout8, d8} !== 9'd0) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b done=%b bout=%b d=%h, required busy=1 done=0 cleared result",
                     busy8, done8, bout8, d8);
        end
        lat2 = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done8) begin
                lat2 = i;
                break;
            end
        end
        n_checks++;
        if (lat2 !== 5 || {bout8, d8} !== exp2) begin
            n_fail++;
            $display("FAIL b2b_second: lat=%0d bout=%b d=%h, required lat=5 bout=%b d=%h",
                     lat2, bout8, d8, exp2[8], exp2[7:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_run();
        logic [8:0] exp, res;
        int n_done, lat;
        a8 = 8'hC3; b8 = 8'h77; bin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({state8, busy8, done8, bout8, d8} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_in_run: state=%0d busy=%b done=%b bout=%b d=%h, required all zero",
                     state8, busy8, done8, bout8, d8);
        end
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done8) n_done++;
        end
        n_checks++;
        if (n_done !== 0) begin
            n_fail++;
            $display("FAIL reset_in_run_no_done: %0d pulses, required 0", n_done);
        end
        exp = ref8(8'h12, 8'h34, 1'b1);
        do_op8(8'h12, 8'h34, 1'b1, lat, res);
        n_checks++;
        if (lat !== 5 || res !== exp) begin
            n_fail++;
            $display("FAIL reset_in_run_fresh: lat=%0d bout=%b d=%h, required lat=5 bout=%b d=%h",
                     lat, res[8], res[7:0], exp[8], exp[7:0]);
        end
    endtask

    task automatic test_exhaustive_w2();
        logic [4:0] v;
        logic [2:0] exp, res;
        int lat;
        for (int k = 0; k < 32; k++) begin
            v = 5'(k);
            exp = ref2(v[4:3], v[2:1], v[0]);
            do_op2(v[4:3], v[2:1], v[0], lat, res);
            $display("(%0d %0d %0d) => (%0d %0d)", v[4:3], v[2:1], v[0], res[2], res[1:0]);
            n_checks++;
            if (lat !== 2 || res !== exp) begin
                n_fail++;
                $display("FAIL w2[%0d]: lat=%0d bout=%b d=%0d, required lat=2 bout=%b d=%0d",
                         k, lat, res[2], res[1:0], exp[2], exp[1:0]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_start_in_run();
        test_back_to_back();
        test_reset_in_run();
        test_exhaustive_w2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_sub_2bit.md
SERIAL_SUB_2BIT -- requirements
Module: serial_sub_2bit

Interface
REQ-001 Parameter WIDTH, default 8, operand width; SHALL be even and >= 2.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled on rising edge, accepted only in IDLE or DONE.
REQ-005 a  input  WIDTH  minuend, sampled on the accepting edge only.
REQ-006 b  input  WIDTH  subtrahend, sampled on the accepting edge only.
REQ-007 bin  input  1  borrow-in, sampled on the accepting edge only.
REQ-008 busy  output  1  high while the subtraction is in progress (RUN).
REQ-009 done  output  1  one-cycle pulse; d and bout are valid from this cycle.
REQ-010 d  output  WIDTH  difference, a - b - bin modulo 2^WIDTH.
REQ-011 bout  output  1  borrow-out; 1 iff a < b + bin (unsigned).

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
REQ-013 IDLE/DONE + start SHALL move to RUN, latch a, b and bin, and clear d, bout and the pair counter.
REQ-014 RUN SHALL process 2 bits per edge, LSB pair first, chaining the borrow between pairs.
REQ-015 After WIDTH/2 RUN edges, RUN SHALL move to DONE.
REQ-016 Latency: done SHALL go high exactly WIDTH/2+1 edges after the accepting edge (WIDTH=8: 5).
REQ-017 In DONE, done SHALL be 1 for exactly one cycle; the next state is RUN if start=1, else IDLE.
REQ-018 start while in RUN SHALL be ignored; latched operands SHALL be unaffected.
REQ-019 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-020 d and bout SHALL hold the last result through IDLE until the next accepting edge clears them.
REQ-021 Pair arithmetic SHALL be {borrow, diff} = a_pair - b_pair - borrow_in, i.e. a + ~b + ~borrow with the carry inverted.
REQ-022 The pair counter SHALL be ceil(log2(WIDTH/2))+1 bits and SHALL not wrap in RUN.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, busy=0, done=0, d=0, bout=0, counter=0.
REQ-024 rst SHALL override start on the same edge.
REQ-025 rst in RUN SHALL abort without a done pulse; the next operation SHALL be unaffected.

Structure
REQ-026 A shared package serial_sub_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-027 The 2-bit step SHALL be a combinational sub-module fs_2bit, port order (bout, d, bin, a, b).
REQ-028 fs_2bit SHALL be instantiated once and reused every RUN cycle; no WIDTH-wide subtractor.

Verification
REQ-029 WIDTH=8: a=0x05, b=0x03, bin=0 -> d=0x02, bout=0, done 5 edges after start.
REQ-030 WIDTH=8: a=0x03, b=0x05, bin=0 -> d=0xFE, bout=1; a=0x00, b=0x00, bin=1 -> d=0xFF, bout=1.
REQ-031 WIDTH=8: a=0x80, b=0x01, bin=0 -> d=0x7F, bout=0; start pulsed again in RUN -> ignored, one done only.
REQ-032 WIDTH=8: back-to-back, start held high through DONE -> second op accepted on the DONE edge, results correct.
REQ-033 WIDTH=8: rst asserted on the 2nd RUN edge -> IDLE, outputs 0, no done; a fresh op then gives a correct result.
REQ-034 WIDTH=2: exhaustive loop over {a,b,bin} = 0..31 -> {bout,d} == a - b - bin, printed as "(a b bin) => (bout d)".
